// File: rtl/pong_match_ctrl.sv
// Game-flow controller for the tennis playfield core: attract/play/pause/over
// sequencing plus joystick/mouse arbitration into per-frame bat move words.
module pong_match_ctrl #(
   parameter int JOY_SPEED   = 4,
   parameter int MAX_STEP    = 63,
   parameter int IDLE_FRAMES = 1500,
   parameter int OVER_FRAMES = 250,
   parameter int WIN_SCORE   = 15
) (
   input  logic       glb_clk,
   input  logic       reset,
   input  logic       vsync,
   input  logic       key_start,
   input  logic       key_pause,
   input  logic [1:0] joy_l,
   input  logic [1:0] joy_r,
   input  logic [8:0] mouse_l_dy,
   input  logic       mouse_l_stb,
   input  logic [8:0] mouse_r_dy,
   input  logic       mouse_r_stb,
   input  logic [3:0] l_score,
   input  logic [3:0] r_score,
   output logic       game_reset,
   output logic       pause,
   output logic       lbat_human,
   output logic       rbat_human,
   output logic [8:0] lbat_move,
   output logic [8:0] rbat_move,
   output logic [1:0] state
);
   localparam int IDLE_W = $clog2(IDLE_FRAMES + 1);
   localparam int OVER_W = $clog2(OVER_FRAMES + 1);
   localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(IDLE_FRAMES);
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_FRAMES - 1);
   localparam logic [OVER_W-1:0] OVER_LAST = OVER_W'(OVER_FRAMES - 1);
   localparam logic [3:0]  WIN    = 4'(WIN_SCORE);
   localparam logic [8:0]  JOY_UP = 9'(JOY_SPEED);
   localparam logic [8:0]  JOY_DN = 9'(-JOY_SPEED);
   localparam logic signed [10:0] MAX_P = 11'(MAX_STEP);
   localparam logic signed [10:0] MAX_N = -MAX_P;

   typedef enum logic [1:0] {ATTRACT = 2'd0, PLAY = 2'd1, PAUSED = 2'd2, OVER = 2'd3} phase_t;

   phase_t            cur_state, nxt_state;
   logic              game_reset_nxt;
   logic [1:0]        mask_cnt;
   logic [OVER_W-1:0] over_cnt;
   logic [6:0]        sync1, sync2;
   logic [2:0]        sync_q;
   logic              start_evt, pause_evt, frame_tick;

   function automatic logic signed [9:0] sat_step(input logic signed [10:0] v);
      if (v > MAX_P)      return MAX_P[9:0];
      else if (v < MAX_N) return MAX_N[9:0];
      return v[9:0];
   endfunction

   // Pins are {vsync, start, pause, joy_l, joy_r}; edge pulses land 3 cycles after the pin
   always_ff @(posedge glb_clk or posedge reset) begin
      if (reset) begin
         sync1      <= '0;
         sync2      <= '0;
         sync_q     <= '0;
         start_evt  <= 1'b0;
         pause_evt  <= 1'b0;
         frame_tick <= 1'b0;
      end else begin
         sync1      <= {vsync, key_start, key_pause, joy_l, joy_r};
         sync2      <= sync1;
         sync_q     <= sync2[6:4];
         start_evt  <= sync2[5] & ~sync_q[1];
         pause_evt  <= sync2[4] & ~sync_q[0];
         frame_tick <= sync_q[2] & ~sync2[6];
      end
   end

   // Win outranks pause in PLAY; start outranks pause in PAUSED
   always_comb begin
      nxt_state      = cur_state;
      game_reset_nxt = 1'b0;
      case (cur_state)
         ATTRACT: begin
            if (start_evt) begin
               nxt_state      = PLAY;
               game_reset_nxt = 1'b1;
            end
         end
         PLAY: begin
            if (mask_cnt == 2'd0 && (l_score == WIN || r_score == WIN))
               nxt_state = OVER;
            else if (pause_evt)
               nxt_state = PAUSED;
         end
         PAUSED: begin
            if (start_evt) begin
               nxt_state      = ATTRACT;
               game_reset_nxt = 1'b1;
            end else if (pause_evt) begin
               nxt_state = PLAY;
            end
         end
         OVER: begin
            if (start_evt) begin
               nxt_state      = PLAY;
               game_reset_nxt = 1'b1;
            end else if (frame_tick && over_cnt == OVER_LAST) begin
               nxt_state      = ATTRACT;
               game_reset_nxt = 1'b1;
            end
         end
         default: nxt_state = ATTRACT;
      endcase
   end

   always_ff @(posedge glb_clk or posedge reset) begin
      if (reset) begin
         cur_state  <= ATTRACT;
         game_reset <= 1'b0;
         pause      <= 1'b0;
         mask_cnt   <= '0;
         over_cnt   <= '0;
      end else begin
         cur_state  <= nxt_state;
         game_reset <= game_reset_nxt;
         pause      <= (nxt_state == PAUSED) || (nxt_state == OVER);
         if (game_reset_nxt)
            mask_cnt <= 2'd2;
         else if (frame_tick && mask_cnt != 2'd0)
            mask_cnt <= mask_cnt - 2'd1;
         if (nxt_state != OVER)
            over_cnt <= '0;
         else if (cur_state == OVER && frame_tick)
            over_cnt <= over_cnt + 1'b1;
      end
   end

   for (genvar s = 0; s < 2; s++) begin : g_side
      logic [8:0]        dy;
      logic              stb;
      logic [1:0]        joy;
      logic signed [9:0] acc;
      logic [10:0]       dy_ext, acc_sum;
      logic [8:0]        mv;
      logic [8:0]        move_q;
      logic              human_q;
      logic [IDLE_W-1:0] idle;

      assign dy  = (s == 0) ? mouse_l_dy  : mouse_r_dy;
      assign stb = (s == 0) ? mouse_l_stb : mouse_r_stb;
      assign joy = (s == 0) ? sync2[3:2]  : sync2[1:0];

      // Pending mouse motion beats the joystick; conflicting joystick directions cancel
      always_comb begin
         dy_ext  = {{2{dy[8]}}, dy};
         acc_sum = {acc[9], acc} + dy_ext;
         if (acc != '0)
            mv = acc[8:0];
         else if (joy == 2'b10)
            mv = JOY_UP;
         else if (joy == 2'b01)
            mv = JOY_DN;
         else
            mv = '0;
      end

      always_ff @(posedge glb_clk or posedge reset) begin
         if (reset) begin
            acc     <= '0;
            move_q  <= '0;
            human_q <= 1'b0;
            idle    <= '0;
         end else begin
            if (frame_tick) begin
               acc    <= stb ? sat_step(dy_ext) : '0;
               move_q <= (cur_state == PLAY) ? mv : '0;
            end else if (stb) begin
               acc <= sat_step(acc_sum);
            end
            if (game_reset_nxt || cur_state == ATTRACT) begin
               idle    <= '0;
               human_q <= 1'b0;
            end else if (cur_state == PLAY && frame_tick) begin
               if (mv != '0) begin
                  idle    <= '0;
                  human_q <= 1'b1;
               end else if (idle != IDLE_MAX) begin
                  idle <= idle + 1'b1;
                  if (idle == IDLE_LAST)
                     human_q <= 1'b0;
               end
            end
         end
      end
   end

   assign lbat_move  = g_side[0].move_q;
   assign rbat_move  = g_side[1].move_q;
   assign lbat_human = g_side[0].human_q;
   assign rbat_human = g_side[1].human_q;
   assign state      = cur_state;

endmodule

// File: doc/pong_match_ctrl.md
Name: pong_match_ctrl

Overview:
- Game-flow controller for the tennis playfield core: sequences attract, play, pause and game-over phases, and drives that core's reset, pause and human/auto flags.
- Arbitrates two bat input sources per side, a digital joystick and a mouse Y-delta, into the 9-bit per-frame move words.
- Move words are updated at vsync fall and held stable across the core's rising-vsync sample point.

Parameters:
JOY_SPEED, 4, joystick step per frame (lines)
MAX_STEP, 63, saturation magnitude of move word
IDLE_FRAMES, 1500, frames without input before a side reverts to autoplayer
OVER_FRAMES, 250, game-over display frames before returning to attract
WIN_SCORE, 15, score that ends a game

Ports:
glb_clk  in  1  system clock
reset  in  1  asynchronous, active-high
vsync  in  1  negative vsync from playfield core
key_start  in  1  start key level, asynchronous
key_pause  in  1  pause key level, asynchronous
joy_l  in  2  left joystick {up,down}, levels, asynchronous
joy_r  in  2  right joystick {up,down}, levels, asynchronous
mouse_l_dy  in  9  left mouse Y delta, two's complement, up positive
mouse_l_stb  in  1  one-cycle strobe, mouse_l_dy valid
mouse_r_dy  in  9  right mouse Y delta
mouse_r_stb  in  1  strobe for mouse_r_dy
l_score  in  4  left score from core
r_score  in  4  right score from core
game_reset  out  1  one-cycle pulse resetting the core
pause  out  1  freeze ball/bats
lbat_human  out  1  left side under human control
rbat_human  out  1  right side under human control
lbat_move  out  9  left move word, positive = up
rbat_move  out  9  right move word
state  out  2  0 ATTRACT, 1 PLAY, 2 PAUSED, 3 OVER

Behaviour:
- Reset values: state=ATTRACT, game_reset=0, pause=0, both human flags=0, both moves=0, accumulators, idle and over counters=0.
- key_start, key_pause, joy_* pass through 2-FF synchronisers, then rising-edge detection. Start and pause events are one-cycle pulses, 3 cycles after the pin edge.
- frame_tick: one cycle on each synchronised falling edge of vsync.
- Mouse accumulator per side:
  - 10-bit signed; each stb adds sign-extended dy, saturating at ±MAX_STEP.
  - On frame_tick the accumulator is transferred and cleared.
  - A stb in the same cycle as frame_tick starts the new accumulation with that dy.
- Per-side move source, computed at frame_tick:
  - Mouse accumulator nonzero: move = accumulator.
  - Otherwise joystick up only: move = +JOY_SPEED.
  - Joystick down only: move = -JOY_SPEED.
  - Both or neither: move = 0.
- Activity = move nonzero. Activity sets the side's human flag and clears its idle counter; otherwise the counter increments, saturating. When it reaches IDLE_FRAMES the flag clears.
- Outputs lbat_move/rbat_move register on frame_tick and change at no other time.
- FSM:
  - ATTRACT: human flags forced 0, moves forced 0. Start event → PLAY, game_reset pulse, idle counters cleared, human flags 0 until activity.
  - PLAY: if l_score or r_score == WIN_SCORE → OVER with pause=1; else pause event → PAUSED with pause=1. Win outranks pause in the same cycle. Start is ignored.
  - PAUSED: moves forced 0, human flags and idle counters frozen. Start event → ATTRACT with game_reset and pause=0; else pause event → PLAY with pause=0. Start outranks pause in the same cycle.
  - OVER: moves forced 0, over counter counts frame_ticks. Start event → PLAY with game_reset, pause=0, counter cleared. Counter reaching OVER_FRAMES → ATTRACT with game_reset, pause=0.
- game_reset is exactly one cycle, registered, asserted in the transition cycle. The score check is masked for 2 frames after game_reset, so stale scores cannot re-enter OVER.
- Reset mid-frame or mid-pulse returns every output to its reset value immediately (asynchronous).

Test Plan:
- Reset, 3 frames → state=0, pause=0, humans=0, moves=0, no game_reset.
- key_start rise in ATTRACT → game_reset high for exactly 1 cycle, state=1. Hold joy_l up → next frame_tick lbat_move=9'h004, lbat_human=1.
- Two mouse_l_stb with dy=+40 in one frame → lbat_move=63 (saturated). Single dy=9'h1F6 (−10) → lbat_move=9'h1F6. Joystick up held with mouse active → mouse value wins.
- PLAY, no input for 1500 frames → lbat_human drops on frame 1500, lbat_move=0.
- r_score=15 with pause event in the same cycle → state=3, pause=1. After 250 frames → state=0 with game_reset. Start during OVER → state=1 immediately.
- PAUSED, start and pause events in the same cycle → state=0 with game_reset. Assert reset mid-frame → all outputs 0 asynchronously.
